// File: rtl/dec_key_scanner_pkg.sv
// Shared types and constants for the decimal key scanner.
package dec_key_scanner_pkg;

    localparam int unsigned KEY_W   = 10;
    localparam int unsigned DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD
    } scan_state_t;

    // Clearing the lowest set bit leaves something only when two or more bits are set.
    function automatic logic is_multi(input logic [KEY_W-1:0] k);
        return (k & (k - KEY_W'(1))) != '0;
    endfunction

    function automatic logic is_onehot(input logic [KEY_W-1:0] k);
        return (k != '0) && !is_multi(k);
    endfunction

endpackage

// File: rtl/dec_key_scanner_if.sv
// Digit output stream: FIFO head, valid/ready handshake and occupancy.
interface dec_key_scanner_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    import dec_key_scanner_pkg::*;

    logic [DIGIT_W-1:0]          digit_out;
    logic                        digit_valid;
    logic                        digit_ready;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    modport master (
        output digit_out,
        output digit_valid,
        output fifo_count,
        input  digit_ready
    );

    modport slave (
        input  digit_out,
        input  digit_valid,
        input  fifo_count,
        output digit_ready
    );

endinterface

// File: rtl/dec_onehot_to_bcd.sv
// One-hot decimal key to BCD; anything that is not exactly one-hot maps to 0.
module dec_onehot_to_bcd
    import dec_key_scanner_pkg::*;
(
    input  logic [KEY_W-1:0]   onehot,
    output logic [DIGIT_W-1:0] bcd
);

    always_comb begin
        bcd = '0;
        if (is_onehot(onehot)) begin
            for (int unsigned i = 0; i < KEY_W; i++) begin
                if (onehot[i]) bcd = DIGIT_W'(i);
            end
        end
    end

endmodule

// File: rtl/dec_key_scanner.sv
// Debounced decimal key scanner feeding a first-word fall-through BCD digit FIFO.
module dec_key_scanner
    import dec_key_scanner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_W-1:0]   key_in,
    dec_key_scanner_if.master  dig,
    output logic               overflow,
    output logic               multi_key
);

    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam logic [7:0]  CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [AW:0] FULL     = (AW + 1)'(FIFO_DEPTH);

    scan_state_t        state;
    logic [KEY_W-1:0]   captured;
    logic [7:0]         cnt;
    logic [DIGIT_W-1:0] bcd;

    logic [DIGIT_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic               push;
    logic               pop;
    logic               full;
    logic               accept;

    dec_onehot_to_bcd u_bcd (
        .onehot (captured),
        .bcd    (bcd)
    );

    assign push   = (state == DEBOUNCE) && (key_in == captured) && (cnt == CNT_LAST);
    assign full   = (count == FULL);
    assign pop    = (count != '0) && dig.digit_ready;
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign accept = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            captured <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_onehot(key_in)) begin
                        captured <= key_in;
                        cnt      <= '0;
                        state    <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (key_in != captured)  state <= IDLE;
                    else if (cnt == CNT_LAST) state <= HELD;
                    else                      cnt   <= cnt + 8'd1;
                end
                HELD: begin
                    if (key_in == '0) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            multi_key <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            case ({accept, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            overflow  <= push && full && !pop;
            multi_key <= is_multi(key_in);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= bcd;
    end

    assign dig.digit_out   = mem[rd_ptr];
    assign dig.digit_valid = (count != '0);
    assign dig.fifo_count  = count;

endmodule

// File: tb/tb_dec_key_scanner.sv
// Directed vector bench for dec_key_scanner at default parameters.
module tb_dec_key_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] key_in;
    logic       overflow;
    logic       multi_key;

    int vec_count  = 0;
    int miscompares = 0;

    dec_key_scanner_if #(.FIFO_DEPTH(4)) dig ();

    dec_key_scanner #(
        .DEBOUNCE_CYCLES (4),
        .FIFO_DEPTH      (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .dig       (dig),
        .overflow  (overflow),
        .multi_key (multi_key)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [9:0] key;
        logic       rdy;
        logic       valid;
        logic [3:0] digit;
        int         count;
        logic       ovf;
        logic       multi;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [9:0] k, input logic rdy, input logic v,
                       input logic [3:0] d, input int c, input logic o, input logic m);
        vec_t e;
        e.rst = r; e.key = k; e.rdy = rdy; e.valid = v;
        e.digit = d; e.count = c; e.ovf = o; e.multi = m;
        vecs.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read at that same point.
    task automatic step(input logic [9:0] k, input logic rdy, input logic r);
        key_in          = k;
        dig.digit_ready = rdy;
        rst             = r;
        @(posedge clk);
        #1;
    endtask

    // Five stable cycles push on the fifth edge; ready is only raised on that push edge.
    task automatic press(input logic [9:0] k, input logic rdy_push, input logic exp_ovf,
                         input int exp_cnt);
        for (int i = 0; i < 5; i++) begin
            step(k, (i == 4) ? rdy_push : 1'b0, 1'b0);
            check("press_overflow", {31'd0, overflow}, (i == 4) ? {31'd0, exp_ovf} : 32'd0);
        end
        step(10'h000, 1'b0, 1'b0);
        check("release_overflow", {31'd0, overflow}, 32'd0);
        check("press_count", 32'(dig.fifo_count), 32'(exp_cnt));
    endtask

    task automatic pop_expect(input logic [3:0] d);
        check("pop_valid", {31'd0, dig.digit_valid}, 32'd1);
        check("pop_digit", {28'd0, dig.digit_out}, {28'd0, d});
        step(10'h000, 1'b1, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        key_in          = '0;
        dig.digit_ready = 1'b0;
        rst             = 1'b1;

        add(1, 10'h000, 0, 0, 0, 0, 0, 0);
        // Key 7 held ten cycles with the consumer always ready.
        for (int i = 0; i < 10; i++) add(0, 10'h080, 1, i == 4, 4'd7, (i == 4) ? 1 : 0, 0, 0);
        add(0, 10'h000, 1, 0, 0, 0, 0, 0);
        // Bounce on key 2: debounce restarts from the second capture.
        add(0, 10'h004, 1, 0, 0, 0, 0, 0);
        add(0, 10'h004, 1, 0, 0, 0, 0, 0);
        add(0, 10'h000, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) add(0, 10'h004, 1, i == 4, 4'd2, (i == 4) ? 1 : 0, 0, 0);
        add(0, 10'h000, 1, 0, 0, 0, 0, 0);
        // Key 9 with the consumer stalled, then a single pop.
        for (int i = 0; i < 5; i++) add(0, 10'h200, 0, i == 4, 4'd9, (i == 4) ? 1 : 0, 0, 0);
        add(0, 10'h000, 0, 1, 4'd9, 1, 0, 0);
        add(0, 10'h000, 1, 0, 0, 0, 0, 0);
        // Key 0 boundary.
        for (int i = 0; i < 5; i++) add(0, 10'h001, 1, i == 4, 4'd0, (i == 4) ? 1 : 0, 0, 0);
        add(0, 10'h000, 1, 0, 0, 0, 0, 0);
        // Two keys at once: multi_key every cycle, never captured.
        for (int i = 0; i < 6; i++) add(0, 10'h201, 1, 0, 0, 0, 0, 1);
        add(0, 10'h000, 1, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].key, vecs[i].rdy, vecs[i].rst);
            check($sformatf("v%0d_valid", i), {31'd0, dig.digit_valid}, {31'd0, vecs[i].valid});
            check($sformatf("v%0d_count", i), 32'(dig.fifo_count), 32'(vecs[i].count));
            check($sformatf("v%0d_overflow", i), {31'd0, overflow}, {31'd0, vecs[i].ovf});
            check($sformatf("v%0d_multi", i), {31'd0, multi_key}, {31'd0, vecs[i].multi});
            if (vecs[i].valid)
                check($sformatf("v%0d_digit", i), {28'd0, dig.digit_out}, {28'd0, vecs[i].digit});
        end

        // Stalled consumer: fifth press overflows, order preserved.
        step(10'h000, 1'b0, 1'b1);
        press(10'h002, 1'b0, 1'b0, 1);
        press(10'h004, 1'b0, 1'b0, 2);
        press(10'h008, 1'b0, 1'b0, 3);
        press(10'h010, 1'b0, 1'b0, 4);
        press(10'h020, 1'b0, 1'b1, 4);
        for (int d = 1; d <= 4; d++) pop_expect(4'(d));
        check("drain_valid", {31'd0, dig.digit_valid}, 32'd0);

        // Full FIFO, fifth push meets a pop.
        step(10'h000, 1'b0, 1'b1);
        press(10'h002, 1'b0, 1'b0, 1);
        press(10'h004, 1'b0, 1'b0, 2);
        press(10'h008, 1'b0, 1'b0, 3);
        press(10'h010, 1'b0, 1'b0, 4);
        press(10'h020, 1'b1, 1'b0, 4);
        for (int d = 2; d <= 5; d++) pop_expect(4'(d));
        check("drain2_valid", {31'd0, dig.digit_valid}, 32'd0);

        // Reset mid-debounce with two entries queued; held key is a fresh press.
        step(10'h000, 1'b0, 1'b1);
        press(10'h002, 1'b0, 1'b0, 1);
        press(10'h004, 1'b0, 1'b0, 2);
        step(10'h008, 1'b0, 1'b0);
        step(10'h008, 1'b0, 1'b0);
        step(10'h008, 1'b1, 1'b1);
        check("rst_valid", {31'd0, dig.digit_valid}, 32'd0);
        check("rst_count", 32'(dig.fifo_count), 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(10'h008, 1'b0, 1'b0);
            check("repress_valid", {31'd0, dig.digit_valid}, (i == 4) ? 32'd1 : 32'd0);
        end
        check("repress_digit", {28'd0, dig.digit_out}, 32'd3);
        check("repress_count", 32'(dig.fifo_count), 32'd1);
        step(10'h000, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
